hs_ram_arbiter: RTL and testbench
=================================

HS_RAM_ARBITER -- requirements
Module: hs_ram_arbiter

Interface
REQ-001 The block SHALL have parameter AW, default 11, which is the shared work-RAM address width.
REQ-002 The block SHALL have parameter SETTLE, default 16, which is the number of clk_sys cycles between core_pause assertion and grant (range 1..255).
REQ-003 The block SHALL have parameter TIMEOUT, default 65535, which is the maximum grant length in cycles when HS_TIMEOUT_EN is defined.
REQ-004 clk_sys  in  1  system clock; the only clock in the block.
REQ-005 reset_n  in  1  asynchronous, active-low reset.
REQ-006 user_pause  in  1  level; pause requested by the player toggle or by the OSD.
REQ-007 hs_req  in  1  level; the hiscore engine requests the shared RAM port.
REQ-008 hs_addr / hs_wdata / hs_we  in  AW / 8 / 1  hiscore-side RAM access.
REQ-009 cpu_addr / cpu_wdata / cpu_we  in  AW / 8 / 1  game-core-side RAM access.
REQ-010 ram_rdata  in  8  shared RAM read data, valid 1 cycle after the address.
REQ-011 ram_addr / ram_wdata / ram_we  out  AW / 8 / 1  shared RAM port.
REQ-012 cpu_rdata / hs_rdata  out  8 / 8  read data returned to each requester.
REQ-013 hs_gnt  out  1  hiscore owns the port.
REQ-014 core_pause  out  1  drives the game core PAUSE input.
REQ-015 hs_abort  out  1  one-cycle pulse when the watchdog revokes a grant (HS_TIMEOUT_EN only).

Function
REQ-016 The state machine SHALL have states IDLE, PAUSING, GRANT and RELEASE, with a 2-bit state register.
REQ-017 In IDLE, hs_req=1 SHALL move the machine to PAUSING and load the settle counter with SETTLE-1.
REQ-018 In PAUSING, the counter SHALL decrement each cycle; at 0 the machine SHALL enter GRANT, so hs_gnt rises exactly SETTLE cycles after the IDLE->PAUSING transition.
REQ-019 hs_req falling during PAUSING SHALL return the machine to IDLE next cycle, with no grant issued.
REQ-020 In GRANT, hs_gnt SHALL be 1; hs_req=0 SHALL move the machine to RELEASE.
REQ-021 RELEASE SHALL last exactly 2 cycles with hs_gnt=0 and core_pause still asserted, then return to IDLE.
REQ-022 hs_req reasserted during RELEASE SHALL be ignored until IDLE; it SHALL then be re-evaluated normally.
REQ-023 core_pause SHALL equal user_pause OR (state != IDLE), combinationally from registered state, with no glitch on state change.
REQ-024 When hs_gnt=1, the port mux SHALL select the hs_* inputs; otherwise it SHALL select the cpu_* inputs.
REQ-025 The port mux SHALL be combinational; ram_we SHALL be 0 in PAUSING and RELEASE regardless of cpu_we.
REQ-026 hs_rdata SHALL be ram_rdata when the previous cycle was GRANT, else 0.
REQ-027 cpu_rdata SHALL be ram_rdata at all times.
REQ-028 The grant SHALL be non-preemptive; user_pause changes SHALL NOT affect state transitions.

Reset
REQ-029 While reset_n=0, the machine SHALL be in IDLE, the settle and watchdog counters SHALL be 0, and hs_gnt, hs_abort, ram_we and hs_rdata SHALL be 0.
REQ-030 During reset, core_pause SHALL equal user_pause.
REQ-031 Reset asserted mid-GRANT SHALL drop hs_gnt immediately (asynchronously), and the port SHALL revert to cpu_* inputs.
REQ-032 After reset_n rises, the first possible transition SHALL occur on the next clk_sys edge.

Configuration
REQ-033 With HS_TIMEOUT_EN defined, a 16-bit watchdog SHALL count GRANT cycles; reaching TIMEOUT SHALL force RELEASE and pulse hs_abort for 1 cycle.
REQ-034 After an abort, the machine SHALL stay in IDLE until hs_req has been low for at least 1 cycle.
REQ-035 Without HS_TIMEOUT_EN, no watchdog logic SHALL exist, hs_abort SHALL be tied to 0, and GRANT SHALL last until hs_req falls.

Verification
REQ-036 SETTLE=16 with hs_req rising at cycle 0 -> core_pause=1 at cycle 1, hs_gnt=1 at cycle 17, and ram_addr follows hs_addr from cycle 17.
REQ-037 hs_req=1 for cycles 0..5 only -> no hs_gnt, IDLE by cycle 7, and core_pause follows user_pause=0.
REQ-038 In GRANT, hs write of 0x5A to 0x123, then read of 0x123 -> ram_we for one cycle, and hs_rdata=0x5A one cycle after the read address.
REQ-039 hs_req drops with cpu_we=1 held -> ram_we=0 for both RELEASE cycles, then cpu write passes, and core_pause falls with IDLE.
REQ-040 reset_n pulsed low mid-GRANT -> hs_gnt=0 and ram_we=cpu_we within the same cycle; after release, the state is IDLE.
REQ-041 HS_TIMEOUT_EN, TIMEOUT=100, hs_req held high -> hs_abort pulse at grant cycle 100, no re-grant until hs_req has been low for 1 cycle.

Source files
------------

// File: rtl/hs_ram_arbiter.sv
// hs_ram_arbiter: pauses the game core, waits for it to settle, then lends the shared work-RAM port to the hiscore engine.
// Define HS_TIMEOUT_EN to add a grant watchdog that revokes over-long grants and pulses hs_abort.
module hs_ram_arbiter #(
  parameter int AW      = 11,
  parameter int SETTLE  = 16,
  parameter int TIMEOUT = 65535
) (
  input  logic          clk_sys,
  input  logic          reset_n,
  input  logic          user_pause,
  input  logic          hs_req,
  input  logic [AW-1:0] hs_addr,
  input  logic [7:0]    hs_wdata,
  input  logic          hs_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [7:0]    cpu_wdata,
  input  logic          cpu_we,
  input  logic [7:0]    ram_rdata,
  output logic [AW-1:0] ram_addr,
  output logic [7:0]    ram_wdata,
  output logic          ram_we,
  output logic [7:0]    cpu_rdata,
  output logic [7:0]    hs_rdata,
  output logic          hs_gnt,
  output logic          core_pause,
  output logic          hs_abort
);

  // Gray-ordered: every legal transition flips one bit, so the core_pause decode cannot glitch.
  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    PAUSING = 2'b01,
    GRANT   = 2'b11,
    RELEASE = 2'b10
  } state_t;

  localparam logic [7:0] SETTLE_LOAD = 8'(SETTLE - 1);

  state_t     state_r;
  state_t     state_nxt_s;
  logic [7:0] settle_r;
  logic [7:0] settle_nxt_s;
  logic       gnt_d_r;
  logic       gnt_s;
  logic       abort_s;
  logic       block_s;

  assign gnt_s = (state_r == GRANT);

`ifdef HS_TIMEOUT_EN
  localparam logic [15:0] WD_LAST = 16'(TIMEOUT - 1);

  logic [15:0] wd_r;
  logic        aborted_r;

  assign abort_s = gnt_s && hs_req && (wd_r == WD_LAST);
  assign block_s = aborted_r;

  // Watchdog: counts grant cycles, cleared whenever the port is not granted.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      wd_r <= 16'd0;
    end else if (gnt_s) begin
      wd_r <= wd_r + 16'd1;
    end else begin
      wd_r <= 16'd0;
    end
  end

  // After an abort, a new request is only honoured once hs_req has been seen low.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      aborted_r <= 1'b0;
    end else if (abort_s) begin
      aborted_r <= 1'b1;
    end else if (!hs_req) begin
      aborted_r <= 1'b0;
    end else begin
      aborted_r <= aborted_r;
    end
  end
`else
  logic [15:0] unused_timeout_s;

  assign unused_timeout_s = 16'(TIMEOUT);
  assign abort_s          = 1'b0;
  assign block_s          = 1'b0;
`endif

  // State, settle/release counter and delayed grant registers.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state_r  <= IDLE;
      settle_r <= 8'd0;
      gnt_d_r  <= 1'b0;
    end else begin
      state_r  <= state_nxt_s;
      settle_r <= settle_nxt_s;
      gnt_d_r  <= gnt_s;
    end
  end

  // Next-state logic; the counter doubles as the two-cycle release timer.
  always_comb begin
    state_nxt_s  = state_r;
    settle_nxt_s = settle_r;
    case (state_r)
      IDLE: begin
        if (hs_req && !block_s) begin
          state_nxt_s  = PAUSING;
          settle_nxt_s = SETTLE_LOAD;
        end else begin
          state_nxt_s  = IDLE;
          settle_nxt_s = 8'd0;
        end
      end
      PAUSING: begin
        if (!hs_req) begin
          state_nxt_s  = IDLE;
          settle_nxt_s = 8'd0;
        end else if (settle_r == 8'd0) begin
          state_nxt_s  = GRANT;
          settle_nxt_s = 8'd0;
        end else begin
          state_nxt_s  = PAUSING;
          settle_nxt_s = settle_r - 8'd1;
        end
      end
      GRANT: begin
        if (!hs_req || abort_s) begin
          state_nxt_s  = RELEASE;
          settle_nxt_s = 8'd1;
        end else begin
          state_nxt_s  = GRANT;
          settle_nxt_s = 8'd0;
        end
      end
      RELEASE: begin
        if (settle_r == 8'd0) begin
          state_nxt_s  = IDLE;
          settle_nxt_s = 8'd0;
        end else begin
          state_nxt_s  = RELEASE;
          settle_nxt_s = settle_r - 8'd1;
        end
      end
      default: begin
        state_nxt_s  = IDLE;
        settle_nxt_s = 8'd0;
      end
    endcase
  end

  // Port mux; writes are suppressed while the core is settling or being released, and in reset.
  always_comb begin
    ram_addr  = cpu_addr;
    ram_wdata = cpu_wdata;
    ram_we    = 1'b0;
    if (gnt_s) begin
      ram_addr  = hs_addr;
      ram_wdata = hs_wdata;
      ram_we    = hs_we & reset_n;
    end else begin
      ram_addr  = cpu_addr;
      ram_wdata = cpu_wdata;
      ram_we    = cpu_we & reset_n & (state_r == IDLE);
    end
  end

  // Read-data return paths and status outputs.
  always_comb begin
    cpu_rdata = ram_rdata;
    hs_rdata  = 8'd0;
    if (gnt_d_r) begin
      hs_rdata = ram_rdata;
    end else begin
      hs_rdata = 8'd0;
    end
    hs_gnt     = gnt_s;
    hs_abort   = abort_s;
    core_pause = user_pause | (state_r != IDLE);
  end

endmodule

// File: tb/tb_hs_ram_arbiter.sv
// Scoreboard bench for hs_ram_arbiter: a cycle-count reference model predicts every output, a monitor compares.
module tb_hs_ram_arbiter;
  localparam int AW     = 11;
  localparam int SETTLE = 16;
  localparam int TO     = 100;

  typedef struct {
    logic [AW-1:0] addr;
    logic [7:0]    wdata;
    logic          we;
    logic          gnt;
    logic          pause;
    logic          abort;
    logic [7:0]    hs_rd;
    logic [7:0]    cpu_rd;
  } exp_t;

  logic          clk_sys = 1'b0;
  logic          reset_n;
  logic          user_pause, hs_req, hs_we, cpu_we;
  logic [AW-1:0] hs_addr, cpu_addr;
  logic [7:0]    hs_wdata, cpu_wdata;
  bit   [7:0]    ram_rdata;
  logic [AW-1:0] ram_addr;
  logic [7:0]    ram_wdata, cpu_rdata, hs_rdata;
  logic          ram_we, hs_gnt, core_pause, hs_abort;

  hs_ram_arbiter #(.AW(AW), .SETTLE(SETTLE), .TIMEOUT(TO)) dut (
    .clk_sys(clk_sys), .reset_n(reset_n), .user_pause(user_pause), .hs_req(hs_req),
    .hs_addr(hs_addr), .hs_wdata(hs_wdata), .hs_we(hs_we),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_we(cpu_we),
    .ram_rdata(ram_rdata), .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_we(ram_we),
    .cpu_rdata(cpu_rdata), .hs_rdata(hs_rdata), .hs_gnt(hs_gnt),
    .core_pause(core_pause), .hs_abort(hs_abort)
  );

  always #5 clk_sys = ~clk_sys;

  // Shared RAM seen by the DUT: one-cycle read latency, read-before-write.
  bit [7:0] env_mem [0:(1<<AW)-1];
  always @(posedge clk_sys) begin
    ram_rdata <= env_mem[ram_addr];
    if (ram_we) env_mem[ram_addr] <= ram_wdata;
  end

  // Reference model: core busy flag, cycles left to settle, grant length, release cycles left.
  bit [7:0]      m_mem [0:(1<<AW)-1];
  bit            m_busy, m_gnt, m_blocked, m_prev_gnt;
  int            m_wait, m_rel, m_gn;
  bit [7:0]      m_rd;
  logic [AW-1:0] p_addr = '0;
  logic [7:0]    p_wdata = 8'd0;
  logic          p_we = 1'b0;

  exp_t sb_q[$];
  exp_t me;
  int   nchk = 0;
  int   nbad = 0;

  task automatic model_reset();
    m_busy = 1'b0; m_gnt = 1'b0; m_blocked = 1'b0; m_prev_gnt = 1'b0;
    m_wait = 0; m_rel = 0; m_gn = 0;
  endtask

  task automatic model_edge();
    bit ab;
    bit blk_old;
    m_rd = m_mem[p_addr];
    if (p_we) m_mem[p_addr] = p_wdata;
    m_prev_gnt = m_gnt;
    if (!reset_n) begin
      model_reset();
    end else begin
      ab = 1'b0;
`ifdef HS_TIMEOUT_EN
      ab = m_gnt && hs_req && (m_gn == TO);
`endif
      blk_old = m_blocked;
      if (ab) m_blocked = 1'b1;
      else if (!hs_req) m_blocked = 1'b0;
      if (m_gnt) begin
        if (!hs_req || ab) begin m_gnt = 1'b0; m_rel = 2; end
        else m_gn++;
      end else if (m_rel > 0) begin
        m_rel--;
        if (m_rel == 0) m_busy = 1'b0;
      end else if (m_busy) begin
        if (!hs_req) m_busy = 1'b0;
        else begin
          m_wait--;
          if (m_wait == 0) begin m_gnt = 1'b1; m_gn = 1; end
        end
      end else if (hs_req && !blk_old) begin
        m_busy = 1'b1; m_wait = SETTLE;
      end
    end
  endtask

  task automatic cyc(input logic rst, input logic up, input logic req,
                     input logic [AW-1:0] ha, input logic [7:0] hd, input logic hw,
                     input logic [AW-1:0] ca, input logic [7:0] cd, input logic cw);
    exp_t e;
    @(posedge clk_sys);
    model_edge();
    #1;
    reset_n = rst; user_pause = up; hs_req = req;
    hs_addr = ha; hs_wdata = hd; hs_we = hw;
    cpu_addr = ca; cpu_wdata = cd; cpu_we = cw;
    if (!reset_n) model_reset();
    e.addr   = m_gnt ? hs_addr : cpu_addr;
    e.wdata  = m_gnt ? hs_wdata : cpu_wdata;
    e.we     = !reset_n ? 1'b0 : (m_gnt ? hs_we : (m_busy ? 1'b0 : cpu_we));
    e.gnt    = m_gnt;
    e.pause  = user_pause | m_busy;
    e.abort  = 1'b0;
`ifdef HS_TIMEOUT_EN
    e.abort  = m_gnt && hs_req && (m_gn == TO);
`endif
    e.cpu_rd = m_rd;
    e.hs_rd  = m_prev_gnt ? m_rd : 8'd0;
    p_addr = e.addr; p_wdata = e.wdata; p_we = e.we;
    sb_q.push_back(e);
  endtask

  task automatic rcyc(input logic rst, input logic up, input logic req, input logic hw, input logic cw);
    cyc(rst, up, req, AW'($urandom_range(0, 15)), 8'($urandom), hw,
        AW'($urandom_range(0, 15)), 8'($urandom), cw);
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
    nchk++;
    if (act !== exp_v) begin
      nbad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp_v, $time);
    end
  endtask

  // Monitor: outputs are presented every cycle; compare mid-cycle against the queued expectation.
  initial begin
    forever begin
      @(negedge clk_sys);
      if (sb_q.size() != 0) begin
        me = sb_q.pop_front();
        chk("ram_addr",   32'(ram_addr),   32'(me.addr));
        chk("ram_wdata",  32'(ram_wdata),  32'(me.wdata));
        chk("ram_we",     32'(ram_we),     32'(me.we));
        chk("hs_gnt",     32'(hs_gnt),     32'(me.gnt));
        chk("core_pause", 32'(core_pause), 32'(me.pause));
        chk("hs_abort",   32'(hs_abort),   32'(me.abort));
        chk("hs_rdata",   32'(hs_rdata),   32'(me.hs_rd));
        chk("cpu_rdata",  32'(cpu_rdata),  32'(me.cpu_rd));
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    logic req;
    reset_n = 1'b0; user_pause = 1'b0; hs_req = 1'b0; hs_we = 1'b0; cpu_we = 1'b0;
    hs_addr = '0; cpu_addr = '0; hs_wdata = 8'd0; cpu_wdata = 8'd0;
    model_reset();
    for (int i = 0; i < 3; i++) rcyc(1'b0, 1'($urandom), 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) rcyc(1'b1, 1'b0, 1'b0, 1'($urandom), 1'($urandom));
    // Request held: grant expected 17 cycles after the request is first seen.
    for (int i = 0; i < 18; i++) rcyc(1'b1, 1'b0, 1'b1, 1'b0, 1'($urandom));
    cyc(1'b1, 1'b0, 1'b1, AW'(11'h123), 8'h5A, 1'b1, AW'(11'h007), 8'h11, 1'b1);
    cyc(1'b1, 1'b0, 1'b1, AW'(11'h123), 8'h00, 1'b0, AW'(11'h007), 8'h22, 1'b1);
    rcyc(1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
    // Drop the request with the core trying to write through the release window.
    for (int i = 0; i < 5; i++) rcyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    // Short request aborted during settling.
    for (int i = 0; i < 6; i++) rcyc(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) rcyc(1'b1, 1'b0, 1'b0, 1'b0, 1'($urandom));
    // Reset pulse in the middle of a grant.
    for (int i = 0; i < 20; i++) rcyc(1'b1, 1'b0, 1'b1, 1'($urandom), 1'($urandom));
    for (int i = 0; i < 2; i++) rcyc(1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) rcyc(1'b1, 1'b0, 1'b0, 1'b0, 1'($urandom));
    // Random traffic with sticky request levels.
    req = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 39) == 0) req = ~req;
      rcyc(1'b1, 1'($urandom_range(0, 7) == 0), req, 1'($urandom), 1'($urandom));
    end
`ifdef HS_TIMEOUT_EN
    for (int i = 0; i < 2; i++) rcyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 140; i++) rcyc(1'b1, 1'b0, 1'b1, 1'($urandom), 1'($urandom));
    rcyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 30; i++) rcyc(1'b1, 1'b0, 1'b1, 1'($urandom), 1'($urandom));
`endif
    for (int i = 0; i < 3; i++) rcyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 5 && sb_q.size() != 0; i++) @(negedge clk_sys);
    #1;
    chk("scoreboard_drain", 32'(sb_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", nchk, nbad);
    $finish;
  end
endmodule
